// File: rtl/imem_boot_loader.sv
// Boot loader: packs a LEN-prefixed byte stream into 32-bit words and writes instruction memory.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MAX_WORDS  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned ASM_W = 24;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR,
    S_CHK
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   word_idx_q, word_idx_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [ASM_W-1:0]   asm_q, asm_d;
  logic               byte_ready_q, byte_ready_d;
  logic               imem_we_q, imem_we_d;
  logic [31:0]        imem_addr_q, imem_addr_d;
  logic [31:0]        imem_wdata_q, imem_wdata_d;
  logic               core_rst_q, core_rst_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  logic xfer;
  assign xfer = byte_valid & byte_ready_q;

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif

    case (state_q)
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = byte_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = byte_data;
          if (len_d == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if (17'(len_d) > 17'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          // Bytes arrive LSB first; shifting in from the top leaves lane 0 lowest.
          asm_d      = {byte_data, asm_q[ASM_W-1:8]};
          byte_idx_d = byte_idx_q + IDX_W'(1);
`ifdef LOADER_CHECKSUM_EN
          sum_d      = sum_q + byte_data;
`endif
          if (byte_idx_q == IDX_W'(3)) begin
            imem_addr_d  = 32'({word_idx_q[ADDR_WIDTH-1:0], 2'b00});
            imem_wdata_d = {byte_data, asm_q};
            state_d      = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + LEN_W'(1);
        if (word_idx_d == len_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          state_d = (byte_data == sum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_LEN_LO;
    endcase

    byte_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA) ||
                   (state_d == S_ERR) || (state_d == S_CHK);
    imem_we_d    = (state_d == S_WRITE);
    done_d       = (state_d == S_DONE);
    core_rst_d   = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_LEN_LO;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_q   <= core_rst_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader; build with LOADER_CHECKSUM_EN to exercise the checksum path.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_err    = 0;

  imem_boot_loader #(.ADDR_WIDTH(10), .MAX_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Write log and timing monitor, sampled on the falling edge.
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int cyc = 0;
  int last_we_cyc = -10;
  int done_rise_cyc = -1;
  int core_bad = 0;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      last_we_cyc <= cyc;
    end
    if (done === 1'b1 && done_prev === 1'b0) done_rise_cyc <= cyc;
    if (imem_we === 1'b1 && core_rst === 1'b1) core_bad <= core_bad + 1;
    done_prev <= done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until the loader takes it; returns on the next falling edge.
  task automatic send(input logic [7:0] b);
    logic got;
    got = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int n = 0; n < 50 && !got; n++) begin
      got = byte_ready;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    if (!got) check("send_timeout", 32'(got), 32'd1);
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin : stim
    int base;
    int k;
    logic pat [7];
    logic [7:0] bytes4 [4];

    rst = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(byte_ready), 32'd1);

    // Test 1: two-word image
    base = wa.size();
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h05); send(8'h50); send(8'h00);
    check("t1_loading_core_rst", 32'(core_rst), 32'd0);
    check("t1_write0_busy_ready", 32'(byte_ready), 32'd0);
    send(8'h93); send(8'h05); send(8'hA0); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send(8'hA0);
`endif
    repeat (2) @(negedge clk);
    check("t1_nwrites", 32'(wa.size() - base), 32'd2);
    check("t1_addr0", wa[base], 32'h0);
    check("t1_data0", wd[base], 32'h00500513);
    check("t1_addr1", wa[base+1], 32'h4);
    check("t1_data1", wd[base+1], 32'h00A00593);
    check("t1_done", 32'(done), 32'd1);
    check("t1_core_rst", 32'(core_rst), 32'd1);
    check("t1_error", 32'(error), 32'd0);
`ifndef LOADER_CHECKSUM_EN
    check("t1_done_latency", 32'(done_rise_cyc), 32'(last_we_cyc + 1));
`endif
    // Bytes offered in DONE are refused
    byte_valid = 1'b1;
    byte_data = 8'h55;
    repeat (3) @(negedge clk);
    check("t1_done_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    check("t1_done_nwrites", 32'(wa.size() - base), 32'd2);

    // Test 2: empty image
    do_reset();
    check("t2_rst_done", 32'(done), 32'd0);
    base = wa.size();
    send(8'h00);
    send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    check("t2_done", 32'(done), 32'd1);
    check("t2_core_rst", 32'(core_rst), 32'd1);
    @(negedge clk);
    check("t2_nwrites", 32'(wa.size() - base), 32'd0);

    // Test 3: oversize image is rejected and bytes are drained
    do_reset();
    base = wa.size();
    send(8'h01);
    send(8'h04);
    check("t3_error", 32'(error), 32'd1);
    check("t3_core_rst", 32'(core_rst), 32'd0);
    check("t3_ready", 32'(byte_ready), 32'd1);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'hEE);
    check("t3_error_hold", 32'(error), 32'd1);
    check("t3_ready_hold", 32'(byte_ready), 32'd1);
    check("t3_nwrites", 32'(wa.size() - base), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t3_rst_error", 32'(error), 32'd0);
    check("t3_rst_ready", 32'(byte_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t3_len_lo_ready", 32'(byte_ready), 32'd1);
    check("t3_len_lo_error", 32'(error), 32'd0);

    // Test 4: gappy valid across the data bytes
    do_reset();
    base = wa.size();
    send(8'h01);
    send(8'h00);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bytes4 = '{8'h78, 8'h56, 8'h34, 8'h12};
    k = 0;
    for (int i = 0; i < 7; i++) begin
      logic got;
      byte_valid = pat[i];
      byte_data = pat[i] ? bytes4[k] : 8'hFF;
      got = byte_ready;
      @(negedge clk);
      if (pat[i] && got) k++;
    end
    byte_valid = 1'b0;
    check("t4_bytes_taken", 32'(k), 32'd4);
`ifdef LOADER_CHECKSUM_EN
    send(8'h14);
`endif
    repeat (2) @(negedge clk);
    check("t4_nwrites", 32'(wa.size() - base), 32'd1);
    check("t4_addr", wa[base], 32'h0);
    check("t4_data", wd[base], 32'h12345678);
    check("t4_done", 32'(done), 32'd1);

    // Test 5: reset mid-load, then reload a single word
    do_reset();
    base = wa.size();
    send(8'h03); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    check("t5_second_write_live", 32'(imem_we), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("t5_partial_nwrites", 32'(wa.size() - base), 32'd2);
    check("t5_partial_data1", wd[base+1], 32'h88776655);
    @(negedge clk);
    base = wa.size();
    send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD);
    check("t5_reload_core_rst", 32'(core_rst), 32'd0);
    check("t5_reload_done", 32'(done), 32'd0);
    send(8'hDE);
`ifdef LOADER_CHECKSUM_EN
    send(8'h38);
`endif
    repeat (2) @(negedge clk);
    check("t5_nwrites", 32'(wa.size() - base), 32'd1);
    check("t5_addr", wa[base], 32'h0);
    check("t5_data", wd[base], 32'hDEADBEEF);
    check("t5_done", 32'(done), 32'd1);
    check("t5_core_rst", 32'(core_rst), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Test 6: checksum match and mismatch
    do_reset();
    base = wa.size();
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h0A);
    @(negedge clk);
    check("t6_ok_data", wd[base], 32'h04030201);
    check("t6_ok_done", 32'(done), 32'd1);
    check("t6_ok_error", 32'(error), 32'd0);
    do_reset();
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h0B);
    @(negedge clk);
    check("t6_bad_error", 32'(error), 32'd1);
    check("t6_bad_core_rst", 32'(core_rst), 32'd0);
    check("t6_bad_done", 32'(done), 32'd0);
`endif

    check("core_rst_during_write", 32'(core_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
